// File: rtl/sop_chain_accumulator.sv
// sop_chain_accumulator
// Accumulates signed beats from an int_sop_2 chain into a wider frame sum.
// A frame closes on in_last or on its MAX_BEATS-th beat; the closed sum is
// held in a one-entry valid/ready output register with overflow and
// truncation flags.
module sop_chain_accumulator #(
  parameter int IN_W      = 37,
  parameter int ACC_W     = 48,
  parameter int MAX_BEATS = 256,
  parameter int SATURATE  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [IN_W-1:0]        in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ACC_W-1:0]       out_data,
  output logic [$clog2(MAX_BEATS):0]    out_beats,
  output logic                          out_ovf,
  output logic                          out_trunc
);

  localparam int CNT_W = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_BEATS);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  logic [0:0]              state_p0;
  logic signed [ACC_W-1:0] acc_p0;
  logic [CNT_W-1:0]        cnt_p0;
  logic                    ovf_sticky_p0;

  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf;
  logic [CNT_W-1:0]        n;
  logic                    close;
  logic                    accept;
  logic                    drain;

  // Reduce the one-bit-wider sum to ACC_W bits: clamp or wrap on overflow.
  function automatic logic signed [ACC_W-1:0] clamp_sum(input logic signed [ACC_W:0] s);
    logic signed [ACC_W-1:0] r;
    r = s[ACC_W-1:0];
    if ((SATURATE != 0) && (s[ACC_W] != s[ACC_W-1]))
      r = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return r;
  endfunction

  // Input stalls only while a finished result waits and is not being taken.
  assign in_ready = ~(out_valid & ~out_ready);
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  // Beat arithmetic: sign-extend, add with one guard bit, detect frame close.
  always_comb begin
    x_ext    = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    base     = (state_p0 == ACCUM) ? acc_p0 : '0;
    sum_wide = {base[ACC_W-1], base} + {x_ext[ACC_W-1], x_ext};
    ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    sum      = clamp_sum(sum_wide);
    n        = (state_p0 == IDLE) ? CNT_W'(1) : cnt_p0 + CNT_W'(1);
    close    = in_last | (n == MAX_N);
  end

  // Stage p0: open-frame accumulator, beat count and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0      <= IDLE;
      acc_p0        <= '0;
      cnt_p0        <= '0;
      ovf_sticky_p0 <= 1'b0;
    end else if (accept) begin
      if (close) begin
        state_p0      <= IDLE;
        acc_p0        <= '0;
        cnt_p0        <= '0;
        ovf_sticky_p0 <= 1'b0;
      end else begin
        state_p0      <= ACCUM;
        acc_p0        <= sum;
        cnt_p0        <= n;
        ovf_sticky_p0 <= ovf_sticky_p0 | ovf;
      end
    end
  end

  // Output register: a close loads it (replacing a result drained this edge).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
    end else if (accept && close) begin
      out_valid <= 1'b1;
      out_data  <= sum;
      out_beats <= n;
      out_ovf   <= ovf_sticky_p0 | ovf;
      out_trunc <= ~in_last & (n == MAX_N);
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule
